uart_rx_ovs: RTL and testbench
==============================

# uart_rx_ovs

Parametrised, oversampling UART receiver that succeeds the single-rate receiver in the digital-clock UART controller. It synchronises the asynchronous serial line, detects and qualifies the start bit, and samples each bit at mid-bit from an internal oversample tick. It delivers DATA_BITS-wide words with a one-cycle valid strobe plus framing and parity error flags to the command decoder.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- OVERSAMPLE, 16, ticks per bit period; even, ≥ 8.
- CLK_DIV, 27, i_clk cycles per oversample tick; ≥ 1.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.
- i_clk  input  1  single system clock; all logic on the rising edge.
- i_rst_n  input  1  reset; asynchronous assert, active-low.
- i_din  input  1  serial line, idle high, asynchronous to i_clk.
- o_dout  output  DATA_BITS  received word, LSB first on the line; holds until the next o_valid.
- o_valid  output  1  one-cycle pulse; word and error flags valid.
- o_frame_err  output  1  stop bit sampled low; qualified by o_valid.
- o_parity_err  output  1  parity mismatch; qualified by o_valid; constant 0 when parity is compiled out.
- o_busy  output  1  high in every state except IDLE.

## Operation
- i_din passes through a 2-flop synchroniser (reset to 1); all logic uses the synchronised value, din_s.
- Tick generator: free-running counter 0..CLK_DIV-1; tick pulses for one cycle when the counter equals CLK_DIV-1.
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP, BREAK.
- IDLE: if din_s = 0, clear the sample counter and go to START.
- START: count ticks; at tick OVERSAMPLE/2, if din_s = 1, return to IDLE as a glitch with no output. Otherwise clear the sample counter and go to DATA.
- DATA: every OVERSAMPLE ticks, shift din_s into the MSB of the shift register (right shift). After DATA_BITS samples, go to PARITY, or to STOP when parity is compiled out.
- PARITY: after OVERSAMPLE ticks, sample din_s and compare it with the XOR of the data bits, XOR PARITY_ODD. Go to STOP.
- STOP: after OVERSAMPLE ticks, sample din_s.
  - 1: load o_dout, pulse o_valid with o_frame_err = 0, go to IDLE.
  - 0: load o_dout, pulse o_valid with o_frame_err = 1, go to BREAK.
- BREAK: wait for din_s = 1, then go to IDLE. No output during a break.
- Counter widths: sample counter $clog2(OVERSAMPLE) bits; bit counter $clog2(DATA_BITS+1) bits. Both wrap only under FSM control.

## Timing
- Reset values: o_dout = 0, o_valid = 0, o_frame_err = 0, o_parity_err = 0, o_busy = 0. The FSM resets to IDLE and the synchroniser resets to 1.
- Input latency: 2 cycles from i_din to din_s.
- Output latency: o_valid asserts on the cycle after the stop-bit sampling tick.
- Nominal frame length (start edge to o_valid): (1 + DATA_BITS + P + 0.5) × OVERSAMPLE × CLK_DIV cycles, ±CLK_DIV for tick phase, + 3. P = 1 with parity compiled in, else 0.
- o_valid is never high on two consecutive cycles.
- There is no backpressure: the consumer must take the word within one frame time.
- A falling edge in the cycle after STOP→IDLE starts a new frame, so back-to-back frames need no extra idle time.
- Reset asserted mid-frame forces the reset values immediately. The partial frame is discarded and no o_valid is produced.
- o_frame_err and o_parity_err may both be 1 on the same strobe.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state, parity-bit sampling and o_parity_err logic are compiled in; PARITY_ODD selects the sense.
- UART_RX_PARITY_EN undefined: frames have no parity bit, DATA goes directly to STOP, o_parity_err is tied to 0, and PARITY_ODD is ignored.

## Structure
- Package uart_pkg holds:
  - the FSM state enum;
  - the parity-sense constants PAR_EVEN = 0 and PAR_ODD = 1;
  - a localparam helper for the counter widths.
- Sub-module uart_baud_tick (parameter CLK_DIV; ports i_clk, i_rst_n, o_tick) holds the tick generator and is reused by the future transmitter.

## Test plan
Bench setup: CLK_DIV = 4 and OVERSAMPLE = 16, giving 64 cycles per bit.
- Frame 0xA5 (no parity, stop = 1) → o_dout = 0xA5 with one o_valid pulse, both error flags 0, and o_busy low afterwards.
- Low glitch of 20 cycles on an idle line → o_busy pulses, then returns to IDLE with no o_valid.
- Frame 0x3C with stop bit = 0, line held low for 3 further bit times → o_valid with o_frame_err = 1. No further o_valid until the line goes high, then 0x55 is received correctly.
- With UART_RX_PARITY_EN and PARITY_ODD = 0: send 0x07 with parity bit 0 → o_parity_err = 1. Send 0x07 with parity bit 1 → o_parity_err = 0.
- i_rst_n pulsed low during data bit 4 of a frame → all outputs 0 immediately, no o_valid. The next complete frame 0x81 is received correctly.
- Three back-to-back frames 0x00, 0xFF, 0x5A with no idle gap → exactly three o_valid pulses carrying those values in order.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM states, parity-sense constants and a counter
// width helper for the oversampling UART receiver (and the future transmitter).
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  // Receiver FSM states. PARITY exists only when parity is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Parity sense selected by PARITY_ODD.
  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Width of a counter that must hold values 0..n-1. Never returns 0, so a
  // divide-by-one tick counter still gets a legal one-bit register.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-cycle tick every
// CLK_DIV clock cycles. Shared by the receiver and the future transmitter.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 27
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int           CNT_W = cnt_w(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count 0..CLK_DIV-1 and wrap; never stops.
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver. Synchronises the serial line,
// qualifies the start bit at half a bit period, samples every following bit
// at mid-bit and delivers a word with a one-cycle valid strobe plus framing
// and parity error flags.
// Optional feature macro: UART_RX_PARITY_EN (parity bit after the data bits,
// sense selected by PARITY_ODD; o_parity_err is tied low without it).
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int CLK_DIV    = 27,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_din,
  output logic [DATA_BITS-1:0] o_dout,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  // Elaboration-time legality checks on the parameters.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_ovs: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_ovs: OVERSAMPLE must be even and >= 8");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("uart_rx_ovs: CLK_DIV must be >= 1");
  end
  if (PARITY_ODD != PAR_EVEN && PARITY_ODD != PAR_ODD) begin : g_bad_parity_odd
    $error("uart_rx_ovs: PARITY_ODD must be 0 or 1");
  end

  localparam int SMP_W = cnt_w(OVERSAMPLE);
  localparam int BIT_W = cnt_w(DATA_BITS + 1);

  // Tick count at which the start bit is re-checked (half a bit period) and
  // at which every later bit is sampled (one full bit period).
  localparam logic [SMP_W-1:0] HALF_LAST = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0] FULL_LAST = SMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic           PAR_SENSE  = (PARITY_ODD == PAR_ODD);
  localparam rx_state_e      AFTER_DATA = ST_PARITY;
`else
  localparam rx_state_e      AFTER_DATA = ST_STOP;
`endif

  logic [1:0]           sync_q;
  logic                 din_s;
  logic                 tick;

  rx_state_e            state_q;
  logic [SMP_W-1:0]     smp_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] dout_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 busy_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_q;
  logic                 perr_q;
`endif

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (tick)
  );

  // Two-flop synchroniser; resets to the idle-high line level so leaving
  // reset can never look like a start edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_din};
    end
  end

  assign din_s = sync_q[1];

  // Receive FSM with its counters, shift register and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      smp_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      // The strobe lasts one cycle unless the STOP branch raises it again.
      valid_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (!din_s) begin
            smp_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_START;
          end
        end

        ST_START: begin
          if (tick) begin
            if (smp_cnt_q == HALF_LAST) begin
              smp_cnt_q <= '0;
              if (din_s) begin
                // Line went back high before mid start bit: a glitch.
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                bit_cnt_q <= '0;
                state_q   <= ST_DATA;
              end
            end else begin
              smp_cnt_q <= smp_cnt_q + SMP_W'(1);
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (smp_cnt_q == FULL_LAST) begin
              smp_cnt_q <= '0;
              // LSB arrives first, so shifting right leaves it in bit 0.
              shift_q   <= {din_s, shift_q[DATA_BITS-1:1]};
              if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_q <= '0;
                state_q   <= AFTER_DATA;
              end else begin
                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              end
            end else begin
              smp_cnt_q <= smp_cnt_q + SMP_W'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (smp_cnt_q == FULL_LAST) begin
              smp_cnt_q <= '0;
              par_err_q <= (din_s != ((^shift_q) ^ PAR_SENSE));
              state_q   <= ST_STOP;
            end else begin
              smp_cnt_q <= smp_cnt_q + SMP_W'(1);
            end
          end
        end
`endif

        ST_STOP: begin
          if (tick) begin
            if (smp_cnt_q == FULL_LAST) begin
              smp_cnt_q <= '0;
              dout_q    <= shift_q;
              valid_q   <= 1'b1;
              ferr_q    <= ~din_s;
`ifdef UART_RX_PARITY_EN
              perr_q    <= par_err_q;
`endif
              if (din_s) begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                // Stop bit low: treat as a line break until it releases.
                state_q <= ST_BREAK;
              end
            end else begin
              smp_cnt_q <= smp_cnt_q + SMP_W'(1);
            end
          end
        end

        ST_BREAK: begin
          if (din_s) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_dout      = dout_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: directed bench for uart_rx_ovs with a scoreboard of
// expected words filled as frames are driven and drained on o_valid.
`timescale 1ns/1ps
module tb_uart_rx_ovs;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int CLK_DIV    = 4;
  localparam int PARITY_ODD = 0;
  localparam int BIT_CYC    = OVERSAMPLE * CLK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int PARITY_EN  = 1;
`else
  localparam int PARITY_EN  = 0;
`endif
  // Start edge to o_valid: (1 + DATA_BITS + P + 0.5) bits + 3 cycles.
  localparam int NOM_LEN = (1 + DATA_BITS + PARITY_EN) * BIT_CYC + BIT_CYC / 2 + 3;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 ferr;
    logic                 perr;
  } exp_t;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 din   = 1'b1;
  logic [DATA_BITS-1:0] dout;
  logic                 valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors        = 0;
  int   miscompares    = 0;
  int   valid_cnt      = 0;
  int   cyc            = 0;
  int   last_valid_cyc = 0;
  logic prev_valid     = 1'b0;

  uart_rx_ovs #(
    .DATA_BITS  (DATA_BITS),
    .OVERSAMPLE (OVERSAMPLE),
    .CLK_DIV    (CLK_DIV),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_din        (din),
    .o_dout       (dout),
    .o_valid      (valid),
    .o_frame_err  (frame_err),
    .o_parity_err (parity_err),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Output monitor: every strobe is matched against the scoreboard head.
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      check("valid_single_cycle", 32'(prev_valid), 0);
      check("sb_nonempty_at_valid", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("dout", 32'(dout), 32'(mon_e.data));
        check("frame_err", 32'(frame_err), 32'(mon_e.ferr));
        check("parity_err", 32'(parity_err), 32'(mon_e.perr));
      end
    end
    prev_valid = valid;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #3ms;
    $display("FAIL watchdog: observed timeout expected finish (vectors=%0d)", vectors);
    $fatal(1, "watchdog expired");
  end

  // Drive a line level for n cycles; all drives happen on the falling edge.
  task automatic line_hold(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame and, if asked, push the expected result first.
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop_b,
                            input logic par_b, input bit expect_out);
    exp_t e;
    e.data = d;
    e.ferr = ~stop_b;
    e.perr = (PARITY_EN != 0) && (par_b != ((^d) ^ PARITY_ODD[0]));
    if (expect_out) exp_q.push_back(e);
    line_hold(1'b0, BIT_CYC);
    for (int i = 0; i < DATA_BITS; i++) line_hold(d[i], BIT_CYC);
    if (PARITY_EN != 0) line_hold(par_b, BIT_CYC);
    line_hold(stop_b, BIT_CYC);
  endtask

  // Bounded wait for all expected words to come out.
  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 4 * BIT_CYC) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int   base;
    int   t0;
    bit   busy_seen;
    logic [DATA_BITS-1:0] d;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    line_hold(1'b1, 2 * BIT_CYC);

    // Single clean frame 0xA5 with latency check.
    base = valid_cnt;
    t0   = cyc;
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b1);
    wait_drain("a5_drain");
    check("a5_valid_count", 32'(valid_cnt - base), 1);
    check("a5_latency_in_window",
          32'((last_valid_cyc - t0) >= NOM_LEN - CLK_DIV &&
              (last_valid_cyc - t0) <= NOM_LEN + CLK_DIV), 1);
    line_hold(1'b1, 4);
    check("a5_busy_after", 32'(busy), 0);

    // 20-cycle low glitch on an idle line.
    base      = valid_cnt;
    busy_seen = 1'b0;
    din       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    din = 1'b1;
    for (int i = 0; i < 2 * BIT_CYC; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    check("glitch_busy_pulsed", 32'(busy_seen), 1);
    check("glitch_busy_after", 32'(busy), 0);
    check("glitch_no_valid", 32'(valid_cnt - base), 0);

    // Framing error with the line held low (break), then recovery on 0x55.
    base = valid_cnt;
    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b1);
    line_hold(1'b0, 3 * BIT_CYC);
    wait_drain("brk_drain");
    check("brk_one_valid", 32'(valid_cnt - base), 1);
    check("brk_busy_held", 32'(busy), 1);
    line_hold(1'b1, BIT_CYC);
    check("brk_busy_released", 32'(busy), 0);
    check("brk_no_extra_valid", 32'(valid_cnt - base), 1);
    send_frame(8'h55, 1'b1, ^8'h55, 1'b1);
    wait_drain("rec55_drain");
    check("rec55_valid_count", 32'(valid_cnt - base), 2);

`ifdef UART_RX_PARITY_EN
    // Parity mismatch then match on 0x07 (even sense needs parity bit 1).
    base = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    wait_drain("par_drain");
    check("par_valid_count", 32'(valid_cnt - base), 2);
`endif

    // Reset mid-frame during data bit 4; bits 4.. of 0xF1 keep the line high
    // so the tail of the aborted frame cannot look like a start bit.
    base = valid_cnt;
    d    = 8'hF1;
    line_hold(1'b0, BIT_CYC);
    for (int i = 0; i < 4; i++) line_hold(d[i], BIT_CYC);
    line_hold(d[4], BIT_CYC / 2);
    check("mid_busy_before_rst", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_dout", 32'(dout), 0);
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_frame_err", 32'(frame_err), 0);
    check("mid_rst_parity_err", 32'(parity_err), 0);
    check("mid_rst_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    line_hold(d[4], BIT_CYC / 2 - 3);
    for (int i = 5; i < DATA_BITS; i++) line_hold(d[i], BIT_CYC);
    if (PARITY_EN != 0) line_hold(^d, BIT_CYC);
    line_hold(1'b1, 2 * BIT_CYC);
    check("mid_no_valid", 32'(valid_cnt - base), 0);
    send_frame(8'h81, 1'b1, ^8'h81, 1'b1);
    wait_drain("r81_drain");
    check("r81_valid_count", 32'(valid_cnt - base), 1);

    // Three frames back to back with no idle gap.
    base = valid_cnt;
    send_frame(8'h00, 1'b1, ^8'h00, 1'b1);
    send_frame(8'hFF, 1'b1, ^8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1, ^8'h5A, 1'b1);
    wait_drain("b2b_drain");
    line_hold(1'b1, BIT_CYC);
    check("b2b_valid_count", 32'(valid_cnt - base), 3);
    check("b2b_busy_after", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
